// File: rtl/ecu_boot_ctrl.sv
// ecu_boot_ctrl: boot sequencer for the PULPino core.
// Debounces the run switch, sequences core reset and fetch enable, and runs a
// heartbeat watchdog with a bounded retry count before locking out.
// Every counter counts 0..LIMIT-1, so each timed state lasts exactly LIMIT
// cycles and no counter needs to hold its limit value.
module ecu_boot_ctrl #(
    parameter int PWR_DELAY   = 16,
    parameter int FETCH_DELAY = 8,
    parameter int DEB_CYCLES  = 1000,
    parameter int WDT_CYCLES  = 50000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       sw_run,
    input  logic       heartbeat,
    output logic       core_rst_n,
    output logic       fetch_enable,
    output logic [2:0] state_code,
    output logic       wdt_fault,
    output logic [1:0] retry_cnt
);

    localparam int DLY_MAX = (PWR_DELAY > FETCH_DELAY) ? PWR_DELAY : FETCH_DELAY;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int WDT_W   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_HALT    = 3'd3,
        S_FAULT   = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic               sync1, sync2, run_db;
    logic [DEB_W-1:0]   deb_cnt;
    logic [DLY_W-1:0]   dly_cnt, dly_lim;
    logic [WDT_W-1:0]   wdt_cnt;
    logic               dly_done, wdt_hit;
    logic               rst_nxt, fe_nxt;

    // Synchronize the raw switch and accept a new level only after it holds DEB_CYCLES cycles
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            run_db  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= sw_run;
            sync2 <= sync1;
            if (sync2 == run_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                run_db  <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Delay limit depends on which timed state we are in; watchdog expiry excludes heartbeat cycles
    always_comb begin
        dly_lim  = (state == S_RELEASE) ? DLY_W'(FETCH_DELAY - 1) : DLY_W'(PWR_DELAY - 1);
        dly_done = (dly_cnt == dly_lim);
        wdt_hit  = (state == S_RUN) && !heartbeat && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; watchdog expiry outranks a falling run switch
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (dly_done && run_db) state_nxt = S_RELEASE;
            S_RELEASE: if (dly_done) state_nxt = S_RUN;
            S_RUN: begin
                if (wdt_hit)      state_nxt = S_FAULT;
                else if (!run_db) state_nxt = S_HALT;
            end
            S_HALT:    if (run_db) state_nxt = S_RUN;
            S_FAULT: begin
                if (dly_done)
                    state_nxt = (retry_cnt == 2'(MAX_RETRY)) ? S_LOCKOUT : S_RELEASE;
            end
            S_LOCKOUT: state_nxt = S_LOCKOUT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Delay counter restarts on every state change and saturates at its limit
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n)                dly_cnt <= '0;
        else if (state_nxt != state) dly_cnt <= '0;
        else if (!dly_done)          dly_cnt <= dly_cnt + 1'b1;
    end

    // Watchdog: counts idle RUN cycles, frozen in HALT, cleared everywhere else
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            wdt_cnt <= '0;
        end else if (state == S_RUN) begin
            if (heartbeat)                                wdt_cnt <= '0;
            else if (wdt_cnt != WDT_W'(WDT_CYCLES - 1))   wdt_cnt <= wdt_cnt + 1'b1;
        end else if (state == S_HALT) begin
            if (run_db) wdt_cnt <= '0;
        end else begin
            wdt_cnt <= '0;
        end
    end

    // Fault bookkeeping on FAULT entry; retry count saturates
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            wdt_fault <= 1'b0;
            retry_cnt <= 2'd0;
        end else if (state_nxt == S_FAULT && state != S_FAULT) begin
            wdt_fault <= 1'b1;
            if (retry_cnt != 2'(MAX_RETRY)) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Output decode of the upcoming state so registered outputs align with the state register
    always_comb begin
        rst_nxt = 1'b0;
        fe_nxt  = 1'b0;
        case (state_nxt)
            S_RELEASE: rst_nxt = 1'b1;
            S_RUN:     begin rst_nxt = 1'b1; fe_nxt = 1'b1; end
            S_HALT:    rst_nxt = 1'b1;
            default:   begin rst_nxt = 1'b0; fe_nxt = 1'b0; end
        endcase
    end

    // Registered Moore outputs
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            core_rst_n   <= 1'b0;
            fetch_enable <= 1'b0;
            state_code   <= 3'd0;
        end else begin
            core_rst_n   <= rst_nxt;
            fetch_enable <= fe_nxt;
            state_code   <= state_nxt;
        end
    end

endmodule
